// File: rtl/min2_search_ctrl.sv
// Two-minimum search sequencer: frames one search per start pulse, tracks the
// two smallest unsigned EDs of the accepted candidate stream and hands the
// result downstream through a valid/ready handshake.
module min2_search_ctrl #(
  parameter int unsigned ED_W     = 32,
  parameter int unsigned NODE_W   = 32,
  parameter int unsigned MAX_CAND = 64,
  localparam int unsigned CNT_W   = $clog2(MAX_CAND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cand_valid,
  output logic              cand_ready,
  input  logic [ED_W-1:0]   cand_ed,
  input  logic [NODE_W-1:0] cand_node,
  input  logic              cand_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ED_W-1:0]   min1_ed,
  output logic [NODE_W-1:0] min1_node,
  output logic [ED_W-1:0]   min2_ed,
  output logic [NODE_W-1:0] min2_node,
  output logic [CNT_W-1:0]  cand_count,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t r_state;

  logic             w_beat;
  logic             w_lt1;
  logic             w_lt2;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_full;

  // Beat qualification and tracker comparisons (strict, so ties keep rank)
  always_comb begin
    w_beat     = cand_valid && cand_ready;
    w_lt1      = cand_ed < min1_ed;
    w_lt2      = cand_ed < min2_ed;
    w_cnt_nxt  = cand_count + CNT_W'(1);
    w_cnt_full = (w_cnt_nxt == CNT_W'(MAX_CAND));
  end

  // Sequencer with registered outputs; start clears trackers and opens a search
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      cand_ready <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      cand_count <= '0;
      min1_ed    <= '1;
      min2_ed    <= '1;
      min1_node  <= '0;
      min2_node  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_SCAN;
            cand_ready <= 1'b1;
            busy       <= 1'b1;
            overflow   <= 1'b0;
            cand_count <= '0;
            min1_ed    <= '1;
            min2_ed    <= '1;
            min1_node  <= '0;
            min2_node  <= '0;
          end
        end
        ST_SCAN: begin
          if (start) begin
            // Restart: any beat presented this cycle is discarded
            overflow   <= 1'b0;
            cand_count <= '0;
            min1_ed    <= '1;
            min2_ed    <= '1;
            min1_node  <= '0;
            min2_node  <= '0;
          end else if (w_beat) begin
            cand_count <= w_cnt_nxt;
            if (w_lt1) begin
              min2_ed   <= min1_ed;
              min2_node <= min1_node;
              min1_ed   <= cand_ed;
              min1_node <= cand_node;
            end else if (w_lt2) begin
              min2_ed   <= cand_ed;
              min2_node <= cand_node;
            end
            if (cand_last || w_cnt_full) begin
              r_state    <= ST_EMIT;
              cand_ready <= 1'b0;
              res_valid  <= 1'b1;
              overflow   <= !cand_last;
            end
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            r_state   <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          cand_ready <= 1'b0;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min2_search_ctrl.sv
// Scoreboard bench for min2_search_ctrl: instance A uses the default candidate
// limit, instance B a limit of 4 for the force-close case.
module tb_min2_search_ctrl;

  localparam int unsigned ED_W   = 32;
  localparam int unsigned NODE_W = 32;
  localparam int unsigned CW_A   = $clog2(64 + 1);
  localparam int unsigned CW_B   = $clog2(4 + 1);
  localparam logic [ED_W-1:0] ED_MAX = '1;

  typedef struct {
    logic [ED_W-1:0]   m1e;
    logic [NODE_W-1:0] m1n;
    logic [ED_W-1:0]   m2e;
    logic [NODE_W-1:0] m2n;
    int unsigned       cnt;
    logic              ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic [ED_W-1:0]   cand_ed = '0;
  logic [NODE_W-1:0] cand_node = '0;
  logic cand_last = 1'b0;
  logic res_ready = 1'b1;

  logic              rdy_a, rv_a, ovf_a, busy_a;
  logic [ED_W-1:0]   m1e_a, m2e_a;
  logic [NODE_W-1:0] m1n_a, m2n_a;
  logic [CW_A-1:0]   cnt_a;
  logic              rdy_b, rv_b, ovf_b, busy_b;
  logic [ED_W-1:0]   m1e_b, m2e_b;
  logic [NODE_W-1:0] m1n_b, m2n_b;
  logic [CW_B-1:0]   cnt_b;

  int errors = 0;
  int checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  min2_search_ctrl #(.ED_W(ED_W), .NODE_W(NODE_W), .MAX_CAND(64)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cand_valid(valid_a), .cand_ready(rdy_a),
    .cand_ed(cand_ed), .cand_node(cand_node), .cand_last(cand_last),
    .res_valid(rv_a), .res_ready(res_ready), .min1_ed(m1e_a), .min1_node(m1n_a),
    .min2_ed(m2e_a), .min2_node(m2n_a), .cand_count(cnt_a), .overflow(ovf_a), .busy(busy_a)
  );

  min2_search_ctrl #(.ED_W(ED_W), .NODE_W(NODE_W), .MAX_CAND(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cand_valid(valid_b), .cand_ready(rdy_b),
    .cand_ed(cand_ed), .cand_node(cand_node), .cand_last(cand_last),
    .res_valid(rv_b), .res_ready(res_ready), .min1_ed(m1e_b), .min1_node(m1n_b),
    .min2_ed(m2e_b), .min2_node(m2n_b), .cand_count(cnt_b), .overflow(ovf_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [ED_W-1:0] m1e, input logic [NODE_W-1:0] m1n,
                              input logic [ED_W-1:0] m2e, input logic [NODE_W-1:0] m2n,
                              input int unsigned cnt, input logic ovf);
    exp_t e;
    e.m1e = m1e; e.m1n = m1n; e.m2e = m2e; e.m2n = m2n; e.cnt = cnt; e.ovf = ovf;
    return e;
  endfunction

  // Monitor A: compare each handshaken result against the queued expectation
  always @(negedge clk) begin
    if (!rst && rv_a && res_ready) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_result", 64'(rv_a), 64'(0));
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_min1_ed", 64'(m1e_a), 64'(e.m1e));
        chk("a_min1_node", 64'(m1n_a), 64'(e.m1n));
        chk("a_min2_ed", 64'(m2e_a), 64'(e.m2e));
        chk("a_min2_node", 64'(m2n_a), 64'(e.m2n));
        chk("a_count", 64'(cnt_a), 64'(e.cnt));
        chk("a_overflow", 64'(ovf_a), 64'(e.ovf));
      end
    end
  end

  // Monitor B: same for the small-limit instance
  always @(negedge clk) begin
    if (!rst && rv_b && res_ready) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_result", 64'(rv_b), 64'(0));
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_min1_ed", 64'(m1e_b), 64'(e.m1e));
        chk("b_min1_node", 64'(m1n_b), 64'(e.m1n));
        chk("b_min2_ed", 64'(m2e_b), 64'(e.m2e));
        chk("b_min2_node", 64'(m2n_b), 64'(e.m2n));
        chk("b_count", 64'(cnt_b), 64'(e.cnt));
        chk("b_overflow", 64'(ovf_b), 64'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_beat(input bit sel, input logic [ED_W-1:0] ed,
                           input logic [NODE_W-1:0] node, input logic last);
    int n = 0;
    while (!(sel ? rdy_b : rdy_a) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("ready_timeout", 64'(0), 64'(1));
    cand_ed = ed; cand_node = node; cand_last = last;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    tick();
    valid_a = 1'b0; valid_b = 1'b0; cand_last = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", 64'(rdy_a), 64'(0));
    chk("rst_res_valid", 64'(rv_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_overflow", 64'(ovf_a), 64'(0));
    chk("rst_count", 64'(cnt_a), 64'(0));
    chk("rst_min1_ed", 64'(m1e_a), 64'(ED_MAX));
    chk("rst_min2_ed", 64'(m2e_a), 64'(ED_MAX));
    chk("rst_min1_node", 64'(m1n_a), 64'(0));
    chk("rst_b_min2_ed", 64'(m2e_b), 64'(ED_MAX));

    // T1: general ordering
    q_a.push_back(mk(2, 3, 4, 1, 5, 1'b0));
    do_start(0);
    chk("t1_busy", 64'(busy_a), 64'(1));
    send_beat(0, 9, 0, 0);
    send_beat(0, 4, 1, 0);
    send_beat(0, 7, 2, 0);
    send_beat(0, 2, 3, 0);
    chk("t1_no_early_result", 64'(rv_a), 64'(0));
    send_beat(0, 8, 4, 1);
    chk("t1_latency", 64'(rv_a), 64'(1));
    chk("t1_ready_low_emit", 64'(rdy_a), 64'(0));
    wait_idle(0);

    // T2: ties keep arrival order
    q_a.push_back(mk(5, 10, 5, 11, 3, 1'b0));
    do_start(0);
    send_beat(0, 5, 10, 0);
    send_beat(0, 5, 11, 0);
    send_beat(0, 5, 12, 1);
    wait_idle(0);

    // T3: single beat, second tracker unfilled, 3-cycle search
    q_a.push_back(mk(3, 7, ED_MAX, 0, 1, 1'b0));
    do_start(0);
    send_beat(0, 3, 7, 1);
    chk("t3_latency", 64'(rv_a), 64'(1));
    wait_idle(0);

    // T4: force-close at limit 4 on instance B
    q_b.push_back(mk(1, 1, 2, 3, 4, 1'b1));
    do_start(1);
    send_beat(1, 6, 0, 0);
    send_beat(1, 1, 1, 0);
    send_beat(1, 3, 2, 0);
    send_beat(1, 2, 3, 0);
    chk("t4_res_valid", 64'(rv_b), 64'(1));
    cand_ed = 0; cand_node = 4; valid_b = 1'b1;
    chk("t4_fifth_not_ready", 64'(rdy_b), 64'(0));
    tick();
    valid_b = 1'b0;
    chk("t4_count_held", 64'(cnt_b), 64'(4));
    wait_idle(1);

    // T6a: restart mid-scan; beat coincident with start is dropped
    q_a.push_back(mk(8, 2, 9, 3, 2, 1'b0));
    do_start(0);
    send_beat(0, 1, 0, 0);
    send_beat(0, 2, 1, 0);
    start_a = 1'b1; valid_a = 1'b1; cand_ed = 0; cand_node = 99;
    tick();
    start_a = 1'b0; valid_a = 1'b0;
    chk("t6_restart_count", 64'(cnt_a), 64'(0));
    chk("t6_restart_busy", 64'(busy_a), 64'(1));
    send_beat(0, 8, 2, 0);
    send_beat(0, 9, 3, 1);
    wait_idle(0);

    // T5: backpressure in EMIT, start ignored
    res_ready = 1'b0;
    q_a.push_back(mk(10, 6, 20, 5, 2, 1'b0));
    do_start(0);
    send_beat(0, 20, 5, 0);
    send_beat(0, 10, 6, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_valid", 64'(rv_a), 64'(1));
      chk("t5_hold_min1", 64'(m1e_a), 64'(10));
      chk("t5_hold_min2n", 64'(m2n_a), 64'(5));
      chk("t5_hold_busy", 64'(busy_a), 64'(1));
      start_a = (i == 3);
      tick();
    end
    start_a = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("t5_idle_after_hs", 64'(busy_a), 64'(0));
    chk("t5_valid_dropped", 64'(rv_a), 64'(0));
    chk("t5_min1_held", 64'(m1e_a), 64'(10));
    chk("t5_count_held", 64'(cnt_a), 64'(2));
    repeat (2) tick();
    chk("t5_start_ignored", 64'(busy_a), 64'(0));

    // T6b: reset mid-scan
    do_start(0);
    send_beat(0, 5, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", 64'(busy_a), 64'(0));
    chk("t6_rst_ready", 64'(rdy_a), 64'(0));
    chk("t6_rst_count", 64'(cnt_a), 64'(0));
    chk("t6_rst_min1_ed", 64'(m1e_a), 64'(ED_MAX));
    chk("t6_rst_min1_node", 64'(m1n_a), 64'(0));
    chk("t6_rst_valid", 64'(rv_a), 64'(0));

    repeat (3) tick();
    chk("a_queue_drained", 64'(q_a.size()), 64'(0));
    chk("b_queue_drained", 64'(q_b.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
